// File: rtl/dsp48a1_mac_ctrl.sv
// Dot-product sequencer for a DSP48A1 slice configured with A1/B1, M, P and
// OPMODE registers. Streams len operand pairs into the slice, lets the
// pipeline drain, then presents the accumulated P as a single-cycle result.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; len=0 requests are flagged and dropped
// S_ISSUE | accepting operand pairs; slice CE follows in_valid
// S_DRAIN | PIPE_LAT enabled cycles flushing the slice pipeline into P
// S_DONE  | res_valid pulse; result registers hold the captured job
module dsp48a1_mac_ctrl #(
    parameter int width1   = 18,
    parameter int width2   = 48,
    parameter int width3   = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [width3-1:0]        len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [width1-1:0] in_a,
    input  logic signed [width1-1:0] in_b,
    output logic [width1-1:0]        dsp_A,
    output logic [width1-1:0]        dsp_B,
    output logic [width3-1:0]        dsp_OPMODE,
    output logic                     dsp_CE,
    output logic                     dsp_RST,
    input  logic [width2-1:0]        dsp_P,
    input  logic                     dsp_CARRYOUT,
    output logic                     busy,
    output logic                     res_valid,
    output logic [width2-1:0]        res_data,
    output logic                     res_ovf,
    output logic                     err_len0
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    // X=M, Z=0 starts a fresh sum; X=M, Z=P accumulates.
    localparam logic [width3-1:0] OPM_FIRST = width3'(8'h01);
    localparam logic [width3-1:0] OPM_ACC   = width3'(8'h09);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [width3-1:0]   len_q, len_d;
    logic [width3-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [width3-1:0]   opmode_q, opmode_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [width2-1:0]   res_data_q, res_data_d;
    logic                res_ovf_q, res_ovf_d;
    logic                err_len0_q, err_len0_d;
    logic                ce;
    logic [width3-1:0]   opm_gen;

    // Next-state, counters, carry accumulation and slice enable.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        xfer_cnt_d  = xfer_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ovf_acc_d   = ovf_acc_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        err_len0_d  = 1'b0;
        ce          = 1'b0;
        opm_gen     = OPM_ACC;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        err_len0_d = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        len_d      = len;
                        xfer_cnt_d = '0;
                        ovf_acc_d  = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                ce = in_valid;
                if (in_valid) begin
                    opm_gen = (xfer_cnt_q == '0) ? OPM_FIRST : OPM_ACC;
                    // P carries stale data until the first product reaches it.
                    if (xfer_cnt_q >= width3'(PIPE_LAT)) begin
                        ovf_acc_d = ovf_acc_q | dsp_CARRYOUT;
                    end
                    if (xfer_cnt_q == len_q - width3'(1)) begin
                        state_d     = S_DRAIN;
                        xfer_cnt_d  = '0;
                        drain_cnt_d = DW'(PIPE_LAT - 1);
                    end else begin
                        xfer_cnt_d = xfer_cnt_q + width3'(1);
                    end
                end
            end
            S_DRAIN: begin
                ce        = 1'b1;
                ovf_acc_d = ovf_acc_q | dsp_CARRYOUT;
                if (drain_cnt_q == '0) begin
                    state_d    = S_DONE;
                    res_data_d = dsp_P;
                    res_ovf_d  = ovf_acc_q | dsp_CARRYOUT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // One enabled cycle of delay lines the opmode up with the M stage.
        opmode_d = ce ? opm_gen : opmode_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            xfer_cnt_q  <= '0;
            drain_cnt_q <= '0;
            opmode_q    <= '0;
            ovf_acc_q   <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            err_len0_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            xfer_cnt_q  <= xfer_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            opmode_q    <= opmode_d;
            ovf_acc_q   <= ovf_acc_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            err_len0_q  <= err_len0_d;
        end
    end

    assign in_ready   = (state_q == S_ISSUE);
    assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign res_valid  = (state_q == S_DONE);
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;
    assign err_len0   = err_len0_q;
    assign dsp_A      = in_ready ? in_a : '0;
    assign dsp_B      = in_ready ? in_b : '0;
    assign dsp_OPMODE = opmode_q;
    assign dsp_CE     = ce;
    assign dsp_RST    = rst;

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Bench for dsp48a1_mac_ctrl driving a behavioural DSP48A1 slice model
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0, synchronous reset).
module tb_dsp48a1_mac_ctrl;

    localparam int W1 = 18;
    localparam int W2 = 48;
    localparam int W3 = 8;
    localparam int PL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W3-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [W1-1:0] in_a, in_b;
    logic [W1-1:0] dsp_A, dsp_B;
    logic [W3-1:0] dsp_OPMODE;
    logic          dsp_CE, dsp_RST;
    logic [W2-1:0] dsp_P;
    logic          dsp_CARRYOUT;
    logic          busy, res_valid, res_ovf, err_len0;
    logic [W2-1:0] res_data;

    dsp48a1_mac_ctrl #(
        .width1(W1), .width2(W2), .width3(W3), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE),
        .dsp_CE(dsp_CE), .dsp_RST(dsp_RST), .dsp_P(dsp_P),
        .dsp_CARRYOUT(dsp_CARRYOUT), .busy(busy), .res_valid(res_valid),
        .res_data(res_data), .res_ovf(res_ovf), .err_len0(err_len0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // Slice model.
    logic signed [17:0] a1_q, b1_q;
    logic signed [35:0] m_q;
    logic [47:0]        p_q, x_mux, z_mux;
    logic [7:0]         opm_q;
    logic               cy_q;
    int                 inj_lo = 1, inj_hi = 0;
    logic               carry_inj;

    always_comb begin
        x_mux = '0;
        z_mux = '0;
        if (opm_q[1:0] == 2'b01) x_mux = {{12{m_q[35]}}, m_q};
        if (opm_q[3:2] == 2'b10) z_mux = p_q;
    end

    always_ff @(posedge clk) begin
        if (dsp_RST) begin
            a1_q <= '0; b1_q <= '0; m_q <= '0; p_q <= '0; opm_q <= '0; cy_q <= 1'b0;
        end else if (dsp_CE) begin
            a1_q  <= dsp_A;
            b1_q  <= dsp_B;
            m_q   <= a1_q * b1_q;
            opm_q <= dsp_OPMODE;
            {cy_q, p_q} <= {1'b0, x_mux} + {1'b0, z_mux};
        end
    end

    assign carry_inj    = (cyc >= inj_lo) && (cyc <= inj_hi);
    assign dsp_P        = p_q;
    assign dsp_CARRYOUT = cy_q | carry_inj;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [47:0] data;
        logic        ovf;
        int          at;
    } exp_t;
    exp_t sb_q[$];

    int ready_total = 0;
    int resv_total  = 0;

    // Result monitor: pops the scoreboard on each res_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (in_ready) ready_total++;
        if (res_valid) begin
            resv_total++;
            if (sb_q.size() == 0) begin
                check("unexpected_res_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("res_data", res_data, e.data);
                check("res_ovf", res_ovf, e.ovf);
                check("res_cycle", cyc, e.at);
            end
        end
    end

    typedef struct {
        int             n;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        int             gap;
        logic [47:0]    exp_data;
        int             lat;
        int             inj_from;
        int             inj_to;
        logic           exp_ovf;
        bit             noisy;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [17:0] a0, b0, a1, b1, a2, b2, a3, b3,
                                input int gap, input logic [47:0] e, input int lat,
                                input int fr, input int to, input logic ov, input bit noisy);
        vec_t v;
        v.n = n; v.a = {a3, a2, a1, a0}; v.b = {b3, b2, b1, b0};
        v.gap = gap; v.exp_data = e; v.lat = lat;
        v.inj_from = fr; v.inj_to = to; v.exp_ovf = ov; v.noisy = noisy;
        return v;
    endfunction

    // Runs one job; called and returns at 1 time unit after a rising edge.
    task automatic run_job(input vec_t v);
        int s0, r0, k, gaps, guard;
        logic rdy, vld;
        s0 = cyc;
        sb_q.push_back('{v.exp_data, v.exp_ovf, s0 + v.lat});
        inj_lo = s0 + v.inj_from;
        inj_hi = s0 + v.inj_to;
        r0 = ready_total;
        start = 1'b1; len = W3'(v.n);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; gaps = 0; guard = 0;
        while (k < v.n && guard < 50) begin
            if (k == 1 && gaps < v.gap) begin
                in_valid = 1'b0; gaps++;
            end else begin
                in_valid = 1'b1; in_a = v.a[k]; in_b = v.b[k];
            end
            if (v.noisy) begin start = 1'b1; len = 8'd1; end
            rdy = in_ready; vld = in_valid;
            @(posedge clk); #1;
            if (rdy && vld) k++;
            guard++;
        end
        in_valid = 1'b0; start = 1'b0; len = '0; in_a = '0; in_b = '0;
        check("xfer_done", k, v.n);
        guard = 0;
        while (sb_q.size() != 0 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        check("res_arrived", sb_q.size(), 0);
        sb_q.delete();
        inj_lo = 1; inj_hi = 0;
        check("ready_cycles", ready_total - r0, v.n + v.gap);
        repeat (2) @(posedge clk);
        #1;
        check("res_data_hold", res_data, v.exp_data);
        check("res_ovf_hold", res_ovf, v.exp_ovf);
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int s0, errs, busy_seen, rv0;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;

        vecs[0] = mk(1, 18'd5, 18'd6, 0, 0, 0, 0, 0, 0, 0, 48'd30, 5, 1, 0, 1'b0, 0);
        vecs[1] = mk(4, 18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8,
                     0, 48'd100, 8, 1, 0, 1'b0, 1);
        vecs[2] = mk(3, 18'd20, 18'd10, 18'd20, 18'd10, 18'd20, 18'd10, 0, 0,
                     2, 48'd600, 9, 1, 0, 1'b0, 0);
        vecs[3] = mk(2, 18'h3FFFD, 18'd7, 18'd2, 18'd2, 0, 0, 0, 0,
                     0, 48'hFFFFFFFFFFEF, 6, 1, 0, 1'b0, 0);
        vecs[4] = mk(2, 18'h20000, 18'h20000, 18'h1FFFF, 18'h1FFFF, 0, 0, 0, 0,
                     0, 48'd34359476225, 6, 1, 0, 1'b0, 0);
        vecs[5] = mk(4, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1,
                     0, 48'd4, 8, 1, 3, 1'b0, 0);
        vecs[6] = mk(4, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1,
                     0, 48'd4, 8, 4, 4, 1'b1, 0);
        vecs[7] = mk(4, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1,
                     0, 48'd4, 8, 7, 7, 1'b1, 0);
        vecs[8] = mk(4, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1,
                     0, 48'd4, 8, 8, 8, 1'b0, 0);

        // Reset state.
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ovf", res_ovf, 0);
        check("rst_err_len0", err_len0, 0);
        check("rst_dsp_A", dsp_A, 0);
        check("rst_dsp_B", dsp_B, 0);
        check("rst_dsp_OPMODE", dsp_OPMODE, 0);
        check("rst_dsp_CE", dsp_CE, 0);
        check("rst_dsp_RST", dsp_RST, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("dsp_RST_follow", dsp_RST, 0);

        for (int i = 0; i < 9; i++) run_job(vecs[i]);

        // len=0 request.
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_len0_pulse", err_len0, 1);
        check("err_len0_busy", busy, 0);
        errs = 0; busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (err_len0) errs++;
            if (busy) busy_seen++;
        end
        check("err_len0_once", errs, 0);
        check("err_len0_busy_after", busy_seen, 0);

        // Reset during ISSUE at the second of four transfers.
        rv0 = resv_total;
        s0 = cyc;
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 18'd1; in_b = 18'd2;
        @(posedge clk); #1;
        in_a = 18'd3; in_b = 18'd4; rst = 1'b1;
        check("abort_in_ready_before", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_cycle", cyc - s0, 3);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_res_valid", resv_total - rv0, 0);
        run_job(mk(1, 18'd5, 18'd6, 0, 0, 0, 0, 0, 0, 0, 48'd30, 5, 1, 0, 1'b0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
